ps_config_seq: RTL and testbench

- Autonomous Passive-Serial configuration sequencer for the on-board FPGA.
- Sequence: nCONFIG pulse, wait for nSTATUS release, byte stream via valid/ready handshake, LSB-first shift on DCLK/DATA0, CONF_DONE detection, trailing init clocks.
- Sits between the host-side bitstream byte source (ZX-BUS port logic or buffer) and the FPGA configuration pins in the CPLD.

---
 rtl/ps_config_seq.sv | 253 +++++++++++++++++++++++++
 tb/tb_ps_config_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps_config_seq.sv
// Passive-Serial configuration sequencer: nCONFIG pulse, nSTATUS wait, LSB-first byte shift, CONF_DONE, init clocks.
// Optional BYTE_CNT output enabled by defining PSCFG_BYTECNT_EN.
module ps_config_seq #(
    parameter int CLK_DIV      = 1,
    parameter int NCFG_LOW_CYC = 100,
    parameter int NSTAT_TMO    = 5000,
    parameter int POST_CLKS    = 16
) (
    input  logic        CLK50,
    input  logic        RST,
    input  logic        START,
    input  logic        ABORT,
    input  logic [7:0]  DIN,
    input  logic        DIN_VALID,
    output logic        DIN_READY,
    output logic        NCONFIG_OE,
    input  logic        NSTATUS,
    input  logic        CONF_DONE,
    output logic        DCLK,
    output logic        DATA0,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [1:0]  ERR_CODE
`ifdef PSCFG_BYTECNT_EN
    ,
    output logic [23:0] BYTE_CNT
`endif
);

    localparam int MAXP_A = (NCFG_LOW_CYC > NSTAT_TMO) ? NCFG_LOW_CYC : NSTAT_TMO;
    localparam int MAXP   = (MAXP_A > POST_CLKS) ? MAXP_A : POST_CLKS;
    localparam int CW     = $clog2(MAXP + 1);
    localparam int PW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CW-1:0] NCFG_LAST = CW'(NCFG_LOW_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(NSTAT_TMO - 1);
    localparam logic [CW-1:0] POST_LAST = CW'(POST_CLKS - 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(CLK_DIV - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_NCFG  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;
    localparam logic [2:0] S_POST  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERROR = 3'd7;

    logic [2:0]    state_q, state_d;
    logic          nst_s_q, nst_q, cd_s_q, cd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [2:0]    bit_q, bit_d;
    logic [6:0]    sh_q, sh_d;
    logic          dclk_q, dclk_d;
    logic          data_q, data_d;
    logic [1:0]    code_q, code_d;
    logic          xfer, ph_last, active;

    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            nst_s_q <= 1'b0;
            nst_q   <= 1'b0;
            cd_s_q  <= 1'b0;
            cd_q    <= 1'b0;
        end else begin
            nst_s_q <= NSTATUS;
            nst_q   <= nst_s_q;
            cd_s_q  <= CONF_DONE;
            cd_q    <= cd_s_q;
        end
    end

    assign DIN_READY  = (state_q == S_LOAD) && !cd_q;
    assign NCONFIG_OE = (state_q == S_NCFG);
    assign BUSY       = (state_q == S_NCFG) || (state_q == S_WAIT) || active;
    assign DONE       = (state_q == S_DONE);
    assign ERR        = (state_q == S_ERROR);
    assign ERR_CODE   = code_q;
    assign DCLK       = dclk_q;
    assign DATA0      = data_q;

    assign active  = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_POST);
    assign xfer    = DIN_VALID && DIN_READY;
    assign ph_last = (ph_q == PH_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        dclk_d  = dclk_q;
        data_d  = data_q;
        code_d  = code_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                ph_d  = '0;
                bit_d = '0;
                if (START) begin
                    state_d = S_NCFG;
                    code_d  = 2'd0;
                end
            end
            S_NCFG: begin
                if (cnt_q == NCFG_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (nst_q) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_ERROR;
                    code_d  = 2'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LOAD: begin
                dclk_d = 1'b0;
                ph_d   = '0;
                bit_d  = '0;
                if (cd_q) begin
                    state_d = S_POST;
                    cnt_d   = '0;
                    data_d  = 1'b0;
                end else if (xfer) begin
                    // Bit 0 goes straight to DATA0; the shifter holds only bits 7:1.
                    state_d = S_SHIFT;
                    data_d  = DIN[0];
                    sh_d    = DIN[7:1];
                end
            end
            S_SHIFT: begin
                if (ph_last) begin
                    ph_d = '0;
                    if (!dclk_q) begin
                        dclk_d = 1'b1;
                    end else begin
                        dclk_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            bit_d   = 3'd0;
                            state_d = S_LOAD;
                        end else begin
                            bit_d  = bit_q + 3'd1;
                            data_d = sh_q[0];
                            sh_d   = {1'b0, sh_q[6:1]};
                        end
                    end
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            S_POST: begin
                data_d = 1'b0;
                if (ph_last) begin
                    ph_d = '0;
                    if (!dclk_q) begin
                        dclk_d = 1'b1;
                    end else begin
                        dclk_d = 1'b0;
                        if (cnt_q == POST_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            default: begin
                dclk_d = 1'b0;
                data_d = 1'b0;
                if (START) begin
                    state_d = S_NCFG;
                    cnt_d   = '0;
                    ph_d    = '0;
                    bit_d   = '0;
                    code_d  = 2'd0;
                end
            end
        endcase

        // Fault exits override normal sequencing; ABORT is checked last so it wins.
        if (active && !nst_q) begin
            state_d = S_ERROR;
            code_d  = 2'd2;
            dclk_d  = 1'b0;
            data_d  = 1'b0;
        end
        if (BUSY && ABORT) begin
            state_d = S_ERROR;
            code_d  = 2'd3;
            dclk_d  = 1'b0;
            data_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ph_q    <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            dclk_q  <= 1'b0;
            data_q  <= 1'b0;
            code_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            dclk_q  <= dclk_d;
            data_q  <= data_d;
            code_q  <= code_d;
        end
    end

`ifdef PSCFG_BYTECNT_EN
    logic [23:0] bc_q, bc_d;

    always_comb begin
        bc_d = bc_q;
        if (state_d == S_NCFG && state_q != S_NCFG) begin
            bc_d = '0;
        end else if (xfer && bc_q != '1) begin
            bc_d = bc_q + 24'd1;
        end
    end

    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            bc_q <= '0;
        end else begin
            bc_q <= bc_d;
        end
    end

    assign BYTE_CNT = bc_q;
`endif

endmodule

// File: tb/tb_ps_config_seq.sv
// Directed bench for ps_config_seq with defaults CLK_DIV=1, NCFG_LOW_CYC=100, NSTAT_TMO=5000, POST_CLKS=16.
module tb_ps_config_seq;

    logic       CLK50 = 1'b0;
    logic       RST, START, ABORT, DIN_VALID, NSTATUS, CONF_DONE;
    logic [7:0] DIN;
    logic       DIN_READY, NCONFIG_OE, DCLK, DATA0, BUSY, DONE, ERR;
    logic [1:0] ERR_CODE;
`ifdef PSCFG_BYTECNT_EN
    logic [23:0] BYTE_CNT;
`endif

    int nerr = 0;
    int nchk = 0;

    ps_config_seq #(
        .CLK_DIV     (1),
        .NCFG_LOW_CYC(100),
        .NSTAT_TMO   (5000),
        .POST_CLKS   (16)
    ) dut (
        .CLK50     (CLK50),
        .RST       (RST),
        .START     (START),
        .ABORT     (ABORT),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
        .DIN_READY (DIN_READY),
        .NCONFIG_OE(NCONFIG_OE),
        .NSTATUS   (NSTATUS),
        .CONF_DONE (CONF_DONE),
        .DCLK      (DCLK),
        .DATA0     (DATA0),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .ERR_CODE  (ERR_CODE)
`ifdef PSCFG_BYTECNT_EN
        ,
        .BYTE_CNT  (BYTE_CNT)
`endif
    );

    always #5 CLK50 = ~CLK50;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] din;
        logic [7:0] seq;   // DATA0 at each DCLK rise, first-sent bit at the left
        int         gap;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge CLK50);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_range(input string nm, input int act, input int lo, input int hi);
        nchk++;
        if (act < lo || act > hi) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic start_to_load();
        int n;
        START = 1'b1;
        tick();
        START = 1'b0;
        n = 0;
        while (NCONFIG_OE && n < 300) begin
            tick();
            n++;
        end
        NSTATUS = 1'b1;
        n = 0;
        while (!DIN_READY && n < 20) begin
            tick();
            n++;
        end
        chk("reach_load", {31'd0, DIN_READY}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] seq,
                             output int rises, output int cycles);
        logic prev;
        DIN       = b;
        DIN_VALID = 1'b1;
        tick();
        DIN_VALID = 1'b0;
        seq    = '0;
        rises  = 0;
        cycles = 0;
        prev   = DCLK;
        while (!DIN_READY && cycles < 100) begin
            tick();
            cycles++;
            if (DCLK && !prev) begin
                rises++;
                seq = {seq[6:0], DATA0};
            end
            prev = DCLK;
        end
    endtask

    initial begin
        logic [7:0] seq;
        int         rises, cycles, n, bad, rdy_seen;
        logic       prev;

        vecs[0] = '{8'hA5, 8'b1010_0101, 0};
        vecs[1] = '{8'h3C, 8'b0011_1100, 0};
        vecs[2] = '{8'h01, 8'b1000_0000, 5};
        vecs[3] = '{8'h80, 8'b0000_0001, 3};
        vecs[4] = '{8'hF0, 8'b0000_1111, 0};
        vecs[5] = '{8'h6E, 8'b0111_0110, 2};

        RST = 1'b1; START = 1'b0; ABORT = 1'b0; DIN = '0; DIN_VALID = 1'b0;
        NSTATUS = 1'b0; CONF_DONE = 1'b0;
        #2;
        chk("reset_outputs", {23'd0, DIN_READY, NCONFIG_OE, DCLK, DATA0, BUSY, DONE, ERR, ERR_CODE}, 32'd0);
        tick();
        tick();
        RST = 1'b0;
        tick();
        chk("idle_busy", {31'd0, BUSY}, 32'd0);

        // nCONFIG pulse width and nSTATUS-to-ready latency
        START = 1'b1;
        tick();
        START = 1'b0;
        n = 0;
        while (NCONFIG_OE && n < 1000) begin
            n++;
            tick();
        end
        chk("ncfg_low_cycles", n, 100);
        NSTATUS = 1'b1;
        n = 0;
        while (!DIN_READY && n < 20) begin
            tick();
            n++;
        end
        chk_range("nstatus_to_ready", n, 2, 3);

        foreach (vecs[i]) begin
            bad = 0;
            for (int g = 0; g < vecs[i].gap; g++) begin
                tick();
                if (DCLK !== 1'b0 || DIN_READY !== 1'b1) bad++;
            end
            chk($sformatf("gap_idle_%0d", i), bad, 0);
            send_byte(vecs[i].din, seq, rises, cycles);
            chk($sformatf("bits_%0d", i), {24'd0, seq}, {24'd0, vecs[i].seq});
            chk($sformatf("rises_%0d", i), rises, 8);
            chk($sformatf("shift_cycles_%0d", i), cycles, 16);
        end

        // CONF_DONE mid-byte: byte finishes, then 16 post clocks with DATA0 low
        DIN       = 8'h5A;
        DIN_VALID = 1'b1;
        tick();
        n = 0; rises = 0; bad = 0; rdy_seen = 0; seq = '0; prev = DCLK;
        while (!DONE && n < 500) begin
            if (n == 5) CONF_DONE = 1'b1;
            tick();
            n++;
            if (DIN_READY) rdy_seen = 1;
            if (DCLK && !prev) begin
                rises++;
                if (rises <= 8) seq = {seq[6:0], DATA0};
                else if (DATA0 !== 1'b0) bad++;
            end
            prev = DCLK;
        end
        DIN_VALID = 1'b0;
        chk("cd_byte_bits", {24'd0, seq}, {24'd0, 8'b0101_1010});
        chk("cd_total_rises", rises, 24);
        chk("post_data0_low", bad, 0);
        chk("post_no_ready", rdy_seen, 0);
        chk("done_flags", {28'd0, DONE, BUSY, DCLK, DIN_READY}, 32'b1000);

        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        tick();
        chk("abort_ignored_done", {30'd0, DONE, ERR}, 32'b10);

        // nSTATUS never released -> timeout
        CONF_DONE = 1'b0;
        NSTATUS   = 1'b0;
        START     = 1'b1;
        tick();
        START = 1'b0;
        chk("restart_clears", {29'd0, NCONFIG_OE, DONE, ERR}, 32'b100);
        n = 0;
        while (NCONFIG_OE && n < 300) begin
            tick();
            n++;
        end
        n = 0;
        while (!ERR && n < 6000) begin
            tick();
            n++;
        end
        chk_range("timeout_cycles", n, 4998, 5003);
        chk("timeout_state", {27'd0, ERR, ERR_CODE, NCONFIG_OE, BUSY}, 32'b10100);

        // nSTATUS dropped during SHIFT
        start_to_load();
        DIN       = 8'hFF;
        DIN_VALID = 1'b1;
        tick();
        DIN_VALID = 1'b0;
        repeat (4) tick();
        NSTATUS = 1'b0;
        n = 0;
        while (!ERR && n < 20) begin
            tick();
            n++;
        end
        chk_range("nst_drop_latency", n, 1, 3);
        chk("nst_drop_state", {28'd0, ERR_CODE, DCLK, DATA0}, 32'b1000);

        // ABORT and synced nSTATUS low reach the FSM on the same edge
        start_to_load();
        DIN       = 8'hFF;
        DIN_VALID = 1'b1;
        tick();
        DIN_VALID = 1'b0;
        repeat (3) tick();
        NSTATUS = 1'b0;
        tick();
        tick();
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("abort_priority", {29'd0, ERR, ERR_CODE}, 32'b111);

        // Asynchronous reset while DCLK is high
        start_to_load();
        DIN       = 8'hFF;
        DIN_VALID = 1'b1;
        tick();
        DIN_VALID = 1'b0;
        n = 0;
        while (!DCLK && n < 10) begin
            tick();
            n++;
        end
        chk("pre_reset_dclk", {30'd0, DCLK, BUSY}, 32'b11);
        RST = 1'b1;
        #1;
        chk("async_reset", {23'd0, DIN_READY, NCONFIG_OE, DCLK, DATA0, BUSY, DONE, ERR, ERR_CODE}, 32'd0);
        tick();
        RST     = 1'b0;
        NSTATUS = 1'b0;
        tick();

`ifdef PSCFG_BYTECNT_EN
        start_to_load();
        DIN       = 8'h96;
        DIN_VALID = 1'b1;
        n = 0;
        cycles = 0;
        while (n < 300 && cycles < 8000) begin
            if (DIN_READY && DIN_VALID) n++;
            if (n == 300) DIN_VALID = 1'b0;
            tick();
            cycles++;
        end
        DIN_VALID = 1'b0;
        repeat (20) tick();
        chk("byte_cnt_300", {8'd0, BYTE_CNT}, 32'd300);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        chk("byte_cnt_cleared", {8'd0, BYTE_CNT}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
